delay_line_sensor: RTL and testbench
====================================

# delay_line_sensor

Parametrised on-chip timing/voltage sensor. A launch flop drives a chain of STAGES dont_touch inverting cells. All taps are captured each clock, converted to a propagation-depth count, and averaged over a programmable window. The result is returned with min/max over a valid/ready handshake. It sits in the sensors group, next to the single inverter cell it instantiates, and feeds hwdbg readout logic.

## Interface
- STAGES, 64: number of inverter cells in the chain (≥2, even).
- SAMPLE_LOG2, 4: window length = 2^SAMPLE_LOG2 samples (0..8).
- SIM_MODEL, 0: 1 = replace the physical chain with a behavioural thermometer driven by sim_depth (bench use only).
- Derived: CNT_W = clog2(STAGES+1); SUM_W = CNT_W+SAMPLE_LOG2.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  0 = stop launching, abort any window, FSM to IDLE.
- start  in  1  one-cycle pulse; begins measurement from IDLE, ignored otherwise.
- continuous  in  1  sampled at start; 1 = back-to-back windows until enable drops.
- sim_depth  in  CNT_W  SIM_MODEL=1 only: number of taps reached per launch (saturates at STAGES).
- result_valid  out  1  result registers hold an untransferred window.
- result_ready  in  1  consumer accepts when high with result_valid.
- result_avg  out  CNT_W  window sum >> SAMPLE_LOG2 (truncating).
- result_min / result_max  out  CNT_W  smallest/largest sample count in the window.
- busy  out  1  FSM not IDLE.
- overrun  out  1  sticky: a completed window overwrote an untransferred result.

## Operation
- Launch flop toggles every cycle while FSM ≠ IDLE; holds value in IDLE.
- Taps t[0..STAGES-1] are captured into tap_q. Odd-indexed taps are inverted to normalise polarity; the whole vector is XORed with the launched value so that "reached" = 1.
- Sample count = popcount of the normalised vector (bubble-tolerant; never a leading-ones scan). Range 0..STAGES.
- Chain cells carry dont_touch; no logic is shared across taps.
- FSM states:
  - IDLE: start & enable -> FILL.
  - FILL: 2 cycles, samples discarded (pipeline fill) -> SAMPLE.
  - SAMPLE: accumulate 2^SAMPLE_LOG2 samples into sum, min, max. On the last sample, load the result registers and set result_valid. Then go to IDLE if continuous=0; otherwise restart the window in SAMPLE with no refill.
- Window restart: sum=0, min=all-ones, max=0, each reloaded from the first sample.
- Handshake: transfer on result_valid & result_ready. After a transfer result_valid drops next cycle unless a new result loads that same cycle, in which case it stays 1 and overrun is not set.
- Overrun: a result loads while result_valid=1 and no transfer happens that cycle. The new result overwrites the old one and overrun is set. overrun clears on reset or on an accepted start.
- enable=0 in any state: go to IDLE next cycle and discard the partial window. result_* and result_valid are unaffected.

## Timing
- Reset values: result_valid=0, result_avg=0, result_min=0, result_max=0, busy=0, overrun=0, launch=0, FSM=IDLE, sum=0.
- Sample pipeline: launch edge at cycle n -> tap_q at n+1 -> popcount register at n+2 -> accumulator at n+3.
- Latency from the start pulse (cycle 0) to result_valid high = 3 + 2^SAMPLE_LOG2 cycles (FILL absorbs 2 pipeline stages, plus 1 for the result register).
- Continuous mode: one result every 2^SAMPLE_LOG2 cycles.
- start while busy: ignored. start while enable=0: ignored.
- reset mid-window: all state returns to reset values on the next edge. No result is produced.
- Accumulator cannot overflow: the worst case STAGES·2^SAMPLE_LOG2 fits in SUM_W.

## Test plan
- SIM_MODEL=1, STAGES=64, SAMPLE_LOG2=4, sim_depth=20, single start, ready=1 -> result_valid at cycle 19 for one cycle; avg=min=max=20; busy low afterwards.
- sim_depth alternating 10/30 per cycle during the window -> avg=20, min=10, max=30.
- sim_depth=64, then 0 -> avg=64 then avg=0 (saturation endpoints); sim_depth=70 -> 64.
- continuous=1, ready=0 across two windows -> second result overwrites first, overrun=1. The next start clears overrun.
- continuous=1, ready pulsed exactly on the load cycle of window 2 -> result_valid stays 1, overrun=0.
- enable dropped mid-SAMPLE, or reset mid-window -> busy=0 next cycle, no result_valid, prior result unchanged (enable case) or cleared to 0 (reset case).

Source files
------------

// File: rtl/delay_line_sensor.sv
// delay_line_sensor: launches a toggling edge into an inverter chain, captures
// every tap each cycle, converts the normalised taps to a propagation depth by
// popcount, and reports avg/min/max over a 2^SAMPLE_LOG2 window via valid/ready.

// Single chain element; instances carry dont_touch so the chain is never merged.
module DelayLineInvCell (
  input  logic a_i,
  output logic y_o
);
  assign y_o = ~a_i;
endmodule

module delay_line_sensor #(
  parameter int STAGES      = 64,
  parameter int SAMPLE_LOG2 = 4,
  parameter bit SIM_MODEL   = 1'b0,
  localparam int CNT_W      = $clog2(STAGES + 1),
  localparam int SUM_W      = CNT_W + SAMPLE_LOG2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             continuous,
  input  logic [CNT_W-1:0] sim_depth,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_avg,
  output logic [CNT_W-1:0] result_min,
  output logic [CNT_W-1:0] result_max,
  output logic             busy,
  output logic             overrun
);

  localparam int IDX_W = (SAMPLE_LOG2 > 0) ? SAMPLE_LOG2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << SAMPLE_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, FILL, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic             fill_q;
  logic             cont_q;
  logic             launch_q, launchCap_q;
  logic [STAGES-1:0] taps, tap_q;
  logic [CNT_W-1:0] popCnt, cnt_q;
  logic [IDX_W-1:0] sampleIdx_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] winMin_q, winMin_d, winMax_q, winMax_d;
  logic             resultValid_q, overrun_q;
  logic [CNT_W-1:0] resultAvg_q, resultMin_q, resultMax_q;
  logic             startAccept, launchEn, sampleEn, lastSample, resultLoad;

  // Tap source: a behavioural thermometer for simulation, or the real chain.
  // A reached tap mirrors the current launch value with its inversion parity.
  if (SIM_MODEL) begin : gSim
    for (genvar g = 0; g < STAGES; g++) begin : gTap
      assign taps[g] = launch_q ^ (g % 2 == 0) ^ ~(sim_depth > CNT_W'(g));
    end
  end else begin : gChain
    logic unusedSimDepth;
    assign unusedSimDepth = ^sim_depth;
    for (genvar g = 0; g < STAGES; g++) begin : gCell
      logic node;
      if (g == 0) begin : gFirst
        (* dont_touch = "true" *)
        DelayLineInvCell uCell (.a_i(launch_q), .y_o(node));
      end else begin : gNext
        (* dont_touch = "true" *)
        DelayLineInvCell uCell (.a_i(gCell[g-1].node), .y_o(node));
      end
      assign taps[g] = node;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; dropping enable forces IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (fill_q) state_d = SAMPLE;
      SAMPLE:  if (lastSample && !cont_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // FSM outputs and derived control strobes.
  always_comb begin
    busy        = (state_q != IDLE);
    launchEn    = (state_q != IDLE);
    sampleEn    = (state_q == SAMPLE);
    startAccept = (state_q == IDLE) && start && enable;
    lastSample  = sampleEn && (sampleIdx_q == LAST_IDX);
    resultLoad  = lastSample && enable;
  end

  // Two-cycle FILL timer plus the continuous flag latched at start.
  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q <= 1'b0;
      cont_q <= 1'b0;
    end else begin
      fill_q <= (state_q == FILL) ? ~fill_q : 1'b0;
      if (startAccept) cont_q <= continuous;
    end
  end

  // Launch flop toggles while busy; taps and the launch value are captured together.
  always_ff @(posedge clock) begin
    if (reset) begin
      launch_q    <= 1'b0;
      launchCap_q <= 1'b0;
      tap_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (launchEn) launch_q <= ~launch_q;
      launchCap_q <= launch_q;
      tap_q       <= taps;
      cnt_q       <= popCnt;
    end
  end

  // Popcount of the polarity-normalised taps, tolerant of bubbles.
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      popCnt = popCnt + CNT_W'(tap_q[i] ^ launchCap_q ^ (i % 2 == 1));
    end
  end

  // Running window statistics including the current sample.
  always_comb begin
    sum_d    = sum_q + SUM_W'(cnt_q);
    winMin_d = (cnt_q < winMin_q) ? cnt_q : winMin_q;
    winMax_d = (cnt_q > winMax_q) ? cnt_q : winMax_q;
  end

  // Window accumulator; reinitialised outside SAMPLE and after the last sample.
  always_ff @(posedge clock) begin
    if (reset || !sampleEn || lastSample) begin
      sum_q       <= '0;
      winMin_q    <= '1;
      winMax_q    <= '0;
      sampleIdx_q <= '0;
    end else begin
      sum_q       <= sum_d;
      winMin_q    <= winMin_d;
      winMax_q    <= winMax_d;
      sampleIdx_q <= sampleIdx_q + 1'b1;
    end
  end

  // Result registers, valid/ready handshake and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      resultValid_q <= 1'b0;
      resultAvg_q   <= '0;
      resultMin_q   <= '0;
      resultMax_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      if (resultLoad) begin
        resultAvg_q   <= CNT_W'(sum_d >> SAMPLE_LOG2);
        resultMin_q   <= winMin_d;
        resultMax_q   <= winMax_d;
        resultValid_q <= 1'b1;
        if (resultValid_q && !result_ready) overrun_q <= 1'b1;
      end else if (resultValid_q && result_ready) begin
        resultValid_q <= 1'b0;
      end
      if (startAccept) overrun_q <= 1'b0;
    end
  end

  assign result_valid = resultValid_q;
  assign result_avg   = resultAvg_q;
  assign result_min   = resultMin_q;
  assign result_max   = resultMax_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_delay_line_sensor.sv
// Directed testbench for delay_line_sensor using the behavioural tap model.
module tb_delay_line_sensor;

  localparam int STAGES      = 64;
  localparam int SAMPLE_LOG2 = 4;
  localparam int CNT_W       = 7;

  logic             clock = 1'b0;
  logic             reset, enable, start, continuous, result_ready;
  logic [CNT_W-1:0] sim_depth;
  logic             result_valid, busy, overrun;
  logic [CNT_W-1:0] result_avg, result_min, result_max;

  int testsRun    = 0;
  int testsFailed = 0;

  delay_line_sensor #(
    .STAGES(STAGES),
    .SAMPLE_LOG2(SAMPLE_LOG2),
    .SIM_MODEL(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .start(start),
    .continuous(continuous),
    .sim_depth(sim_depth),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_avg(result_avg),
    .result_min(result_min),
    .result_max(result_max),
    .busy(busy),
    .overrun(overrun)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Pulse start in the current cycle (cycle 0) and run until result_valid,
  // alternating sim_depth between depA (even cycles) and depB (odd cycles).
  task automatic applyStimulus(input logic [CNT_W-1:0] depA, input logic [CNT_W-1:0] depB,
                               output int lat);
    lat = -1;
    start = 1'b1;
    sim_depth = depA;
    for (int c = 1; c <= 40; c++) begin
      tick;
      start = 1'b0;
      if (result_valid) begin
        lat = c;
        break;
      end
      sim_depth = (c % 2 == 0) ? depA : depB;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; start = 1'b0; continuous = 1'b0;
    result_ready = 1'b1; sim_depth = '0;
    tick; tick;
    reset = 1'b0; enable = 1'b1;
    testsRun++; if (result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0d expected 0", result_valid); end
    testsRun++; if (result_avg !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset_avg: got %0d expected 0", result_avg); end
    testsRun++; if (result_min !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset_min: got %0d expected 0", result_min); end
    testsRun++; if (result_max !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset_max: got %0d expected 0", result_max); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overrun: got %0d expected 0", overrun); end
  endtask

  task automatic test_single;
    int lat;
    continuous = 1'b0; result_ready = 1'b1;
    applyStimulus(7'd20, 7'd20, lat);
    testsRun++; if (lat != 19) begin testsFailed++; $display("[TB] FAIL single_latency: got %0d expected 19", lat); end
    testsRun++; if (result_avg !== 7'd20) begin testsFailed++; $display("[TB] FAIL single_avg: got %0d expected 20", result_avg); end
    testsRun++; if (result_min !== 7'd20) begin testsFailed++; $display("[TB] FAIL single_min: got %0d expected 20", result_min); end
    testsRun++; if (result_max !== 7'd20) begin testsFailed++; $display("[TB] FAIL single_max: got %0d expected 20", result_max); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_busy: got %0d expected 0", busy); end
    tick;
    testsRun++; if (result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_valid_drop: got %0d expected 0", result_valid); end
  endtask

  task automatic test_alternating;
    int lat;
    applyStimulus(7'd10, 7'd30, lat);
    testsRun++; if (lat != 19) begin testsFailed++; $display("[TB] FAIL alt_latency: got %0d expected 19", lat); end
    testsRun++; if (result_avg !== 7'd20) begin testsFailed++; $display("[TB] FAIL alt_avg: got %0d expected 20", result_avg); end
    testsRun++; if (result_min !== 7'd10) begin testsFailed++; $display("[TB] FAIL alt_min: got %0d expected 10", result_min); end
    testsRun++; if (result_max !== 7'd30) begin testsFailed++; $display("[TB] FAIL alt_max: got %0d expected 30", result_max); end
    tick;
  endtask

  task automatic test_saturation;
    int lat;
    applyStimulus(7'd64, 7'd64, lat);
    testsRun++; if (result_avg !== 7'd64) begin testsFailed++; $display("[TB] FAIL sat_full_avg: got %0d expected 64", result_avg); end
    testsRun++; if (result_max !== 7'd64) begin testsFailed++; $display("[TB] FAIL sat_full_max: got %0d expected 64", result_max); end
    tick;
    applyStimulus(7'd0, 7'd0, lat);
    testsRun++; if (result_avg !== 7'd0) begin testsFailed++; $display("[TB] FAIL sat_zero_avg: got %0d expected 0", result_avg); end
    testsRun++; if (result_max !== 7'd0) begin testsFailed++; $display("[TB] FAIL sat_zero_max: got %0d expected 0", result_max); end
    tick;
    applyStimulus(7'd70, 7'd70, lat);
    testsRun++; if (result_avg !== 7'd64) begin testsFailed++; $display("[TB] FAIL sat_over_avg: got %0d expected 64", result_avg); end
    testsRun++; if (result_min !== 7'd64) begin testsFailed++; $display("[TB] FAIL sat_over_min: got %0d expected 64", result_min); end
    tick;
  endtask

  task automatic test_start_ignored;
    enable = 1'b0; start = 1'b1;
    tick;
    start = 1'b0; enable = 1'b1;
    tick;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ign_disabled_busy: got %0d expected 0", busy); end
    continuous = 1'b0; sim_depth = 7'd12; start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      tick;
      start = 1'b0;
      if (c == 5) begin start = 1'b1; continuous = 1'b1; end
      if (c == 6) begin start = 1'b0; continuous = 1'b0; end
    end
    testsRun++; if (result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL ign_busy_valid: got %0d expected 1", result_valid); end
    testsRun++; if (result_avg !== 7'd12) begin testsFailed++; $display("[TB] FAIL ign_busy_avg: got %0d expected 12", result_avg); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ign_busy_stop: got %0d expected 0", busy); end
    tick;
  endtask

  task automatic test_overrun;
    result_ready = 1'b0; continuous = 1'b1; sim_depth = 7'd20; start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick;
      start = 1'b0;
      if (c == 17) sim_depth = 7'd40;
      if (c == 19) begin
        testsRun++; if (result_avg !== 7'd20) begin testsFailed++; $display("[TB] FAIL ovr_first_avg: got %0d expected 20", result_avg); end
        testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_first_flag: got %0d expected 0", overrun); end
      end
    end
    testsRun++; if (result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_second_valid: got %0d expected 1", result_valid); end
    testsRun++; if (result_avg !== 7'd40) begin testsFailed++; $display("[TB] FAIL ovr_second_avg: got %0d expected 40", result_avg); end
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_second_flag: got %0d expected 1", overrun); end
    enable = 1'b0;
    tick;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_stop_busy: got %0d expected 0", busy); end
    enable = 1'b1; continuous = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_clear_on_start: got %0d expected 0", overrun); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_restart_busy: got %0d expected 1", busy); end
    enable = 1'b0;
    tick;
    enable = 1'b1;
  endtask

  task automatic test_ready_on_load;
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    testsRun++; if (result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rol_drain: got %0d expected 0", result_valid); end
    continuous = 1'b1; sim_depth = 7'd20; start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick;
      start = 1'b0;
      if (c == 17) sim_depth = 7'd30;
      if (c == 34) begin
        testsRun++; if (result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rol_pending: got %0d expected 1", result_valid); end
        result_ready = 1'b1;
      end
    end
    result_ready = 1'b0;
    testsRun++; if (result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rol_valid_stays: got %0d expected 1", result_valid); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL rol_no_overrun: got %0d expected 0", overrun); end
    testsRun++; if (result_avg !== 7'd30) begin testsFailed++; $display("[TB] FAIL rol_avg: got %0d expected 30", result_avg); end
    enable = 1'b0;
    tick;
    enable = 1'b1; continuous = 1'b0;
  endtask

  task automatic test_enable_drop;
    int lat;
    bit sawValid;
    result_ready = 1'b1;
    tick;
    applyStimulus(7'd33, 7'd33, lat);
    testsRun++; if (result_avg !== 7'd33) begin testsFailed++; $display("[TB] FAIL en_prior_avg: got %0d expected 33", result_avg); end
    tick;
    sim_depth = 7'd50; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      start = 1'b0;
    end
    enable = 1'b0;
    tick;
    enable = 1'b1;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL en_drop_busy: got %0d expected 0", busy); end
    sawValid = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick;
      if (result_valid) sawValid = 1'b1;
    end
    testsRun++; if (sawValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL en_drop_no_result: got %0d expected 0", sawValid); end
    testsRun++; if (result_avg !== 7'd33) begin testsFailed++; $display("[TB] FAIL en_drop_avg_kept: got %0d expected 33", result_avg); end
    testsRun++; if (result_max !== 7'd33) begin testsFailed++; $display("[TB] FAIL en_drop_max_kept: got %0d expected 33", result_max); end
  endtask

  task automatic test_reset_mid;
    bit sawValid;
    sim_depth = 7'd50; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      start = 1'b0;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_busy: got %0d expected 0", busy); end
    testsRun++; if (result_avg !== 7'd0) begin testsFailed++; $display("[TB] FAIL rst_mid_avg: got %0d expected 0", result_avg); end
    testsRun++; if (result_min !== 7'd0) begin testsFailed++; $display("[TB] FAIL rst_mid_min: got %0d expected 0", result_min); end
    testsRun++; if (result_max !== 7'd0) begin testsFailed++; $display("[TB] FAIL rst_mid_max: got %0d expected 0", result_max); end
    sawValid = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick;
      if (result_valid) sawValid = 1'b1;
    end
    testsRun++; if (sawValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_no_result: got %0d expected 0", sawValid); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset;
    test_single;
    test_alternating;
    test_saturation;
    test_start_ignored;
    test_overrun;
    test_ready_on_load;
    test_enable_drop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
